// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Registered two-master arbiter for the shared internal bus (irom, iram, uart).
// The instruction-fetch port (I) and the load/store port (D) compete for the
// bus. D normally wins a tie. After STARVE_MAX consecutive D grants made while
// I was waiting, I is forced to win. A granted transfer that sees no PREADY for
// TIMEOUT edges is aborted. The abort is signalled with the owner's ready
// pulse plus bus_err.
//
// Ports
//   CLK, RESET            rising-edge clock, asynchronous active-low reset
//   i_req/i_addr          fetch request and address (held until i_ready)
//   i_ready/i_rdata       fetch completion pulse and registered fetch data
//   d_req/d_write/d_addr/d_wdata   load/store request (held until d_ready)
//   d_ready/d_rdata       load/store completion pulse and registered load data
//   bus_err               pulses with the ready pulse of a timed-out transfer
//   PSEL/PADDR/PWRITE/PWDATA       registered slave-side request
//   PRDATA/PREADY         slave read data and completion
//   stall                 pipeline stall: a master waits for its ready pulse
//
// Arbitration looks at the raw request lines. A request that is still high at
// its own completing edge is therefore taken as a new request and served again.
// This lets a master stream back-to-back transfers with PSEL held high.
module mem_bus_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic              bus_err,
    output logic              PSEL,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    output logic              stall
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TMO_ONE    = TW'(1);
    localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
    localparam logic [SW-1:0] STARVE_ONE = SW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        XFER_I = 2'd1,
        XFER_D = 2'd2
    } state_t;

    state_t            state_r,  state_nxt_s;
    logic              psel_r,   psel_nxt_s;
    logic [ADDR_W-1:0] paddr_r,  paddr_nxt_s;
    logic              pwrite_r, pwrite_nxt_s;
    logic [DATA_W-1:0] pwdata_r, pwdata_nxt_s;
    logic              i_ready_r, i_ready_nxt_s;
    logic              d_ready_r, d_ready_nxt_s;
    logic              bus_err_r, bus_err_nxt_s;
    logic [DATA_W-1:0] i_rdata_r, i_rdata_nxt_s;
    logic [DATA_W-1:0] d_rdata_r, d_rdata_nxt_s;
    logic [SW-1:0]     starve_r, starve_nxt_s;
    logic [TW-1:0]     tmo_r,    tmo_nxt_s;
    logic              arb_s;
    logic              grant_i_s;
    logic              grant_d_s;

    // I wins when alone or when D has starved it for STARVE_MAX grants.
    assign grant_i_s = i_req & (~d_req | (starve_r == STARVE_TOP));
    assign grant_d_s = d_req & ~grant_i_s;

    // State and output registers; reset clears everything without a clock edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_r   <= IDLE;
            psel_r    <= 1'b0;
            paddr_r   <= '0;
            pwrite_r  <= 1'b0;
            pwdata_r  <= '0;
            i_ready_r <= 1'b0;
            d_ready_r <= 1'b0;
            bus_err_r <= 1'b0;
            i_rdata_r <= '0;
            d_rdata_r <= '0;
            starve_r  <= '0;
            tmo_r     <= '0;
        end else begin
            state_r   <= state_nxt_s;
            psel_r    <= psel_nxt_s;
            paddr_r   <= paddr_nxt_s;
            pwrite_r  <= pwrite_nxt_s;
            pwdata_r  <= pwdata_nxt_s;
            i_ready_r <= i_ready_nxt_s;
            d_ready_r <= d_ready_nxt_s;
            bus_err_r <= bus_err_nxt_s;
            i_rdata_r <= i_rdata_nxt_s;
            d_rdata_r <= d_rdata_nxt_s;
            starve_r  <= starve_nxt_s;
            tmo_r     <= tmo_nxt_s;
        end
    end

    // Next-state, completion, timeout and arbitration logic.
    always_comb begin
        state_nxt_s   = state_r;
        psel_nxt_s    = psel_r;
        paddr_nxt_s   = paddr_r;
        pwrite_nxt_s  = pwrite_r;
        pwdata_nxt_s  = pwdata_r;
        i_ready_nxt_s = 1'b0;
        d_ready_nxt_s = 1'b0;
        bus_err_nxt_s = 1'b0;
        i_rdata_nxt_s = i_rdata_r;
        d_rdata_nxt_s = d_rdata_r;
        starve_nxt_s  = starve_r;
        tmo_nxt_s     = tmo_r;
        arb_s         = 1'b0;

        case (state_r)
            IDLE: begin
                arb_s = 1'b1;
            end
            XFER_I: begin
                if (PREADY) begin
                    // Ready goes only to a master that is still asking.
                    i_rdata_nxt_s = PRDATA;
                    i_ready_nxt_s = i_req;
                    arb_s         = 1'b1;
                end else if (tmo_r == TMO_LAST) begin
                    i_ready_nxt_s = i_req;
                    bus_err_nxt_s = i_req;
                    psel_nxt_s    = 1'b0;
                    pwrite_nxt_s  = 1'b0;
                    state_nxt_s   = IDLE;
                end else begin
                    tmo_nxt_s = tmo_r + TMO_ONE;
                end
            end
            XFER_D: begin
                if (PREADY) begin
                    // Stores leave d_rdata untouched.
                    if (pwrite_r) begin
                        d_rdata_nxt_s = d_rdata_r;
                    end else begin
                        d_rdata_nxt_s = PRDATA;
                    end
                    d_ready_nxt_s = d_req;
                    arb_s         = 1'b1;
                end else if (tmo_r == TMO_LAST) begin
                    d_ready_nxt_s = d_req;
                    bus_err_nxt_s = d_req;
                    psel_nxt_s    = 1'b0;
                    pwrite_nxt_s  = 1'b0;
                    state_nxt_s   = IDLE;
                end else begin
                    tmo_nxt_s = tmo_r + TMO_ONE;
                end
            end
            default: begin
                psel_nxt_s   = 1'b0;
                pwrite_nxt_s = 1'b0;
                state_nxt_s  = IDLE;
            end
        endcase

        if (arb_s) begin
            if (grant_d_s) begin
                state_nxt_s  = XFER_D;
                psel_nxt_s   = 1'b1;
                paddr_nxt_s  = d_addr;
                pwdata_nxt_s = d_wdata;
                pwrite_nxt_s = d_write;
                tmo_nxt_s    = '0;
            end else if (grant_i_s) begin
                state_nxt_s  = XFER_I;
                psel_nxt_s   = 1'b1;
                paddr_nxt_s  = i_addr;
                pwrite_nxt_s = 1'b0;
                tmo_nxt_s    = '0;
            end else begin
                // PADDR/PWDATA keep their last values while the bus is idle.
                state_nxt_s  = IDLE;
                psel_nxt_s   = 1'b0;
                pwrite_nxt_s = 1'b0;
            end
        end else begin
            arb_s = 1'b0;
        end

        // The starvation count only tracks D grants that overtake a waiting I.
        if (!i_req) begin
            starve_nxt_s = '0;
        end else if (arb_s && grant_i_s) begin
            starve_nxt_s = '0;
        end else if (arb_s && grant_d_s && (starve_r != STARVE_TOP)) begin
            starve_nxt_s = starve_r + STARVE_ONE;
        end else begin
            starve_nxt_s = starve_r;
        end
    end

    assign PSEL    = psel_r;
    assign PADDR   = paddr_r;
    assign PWRITE  = pwrite_r;
    assign PWDATA  = pwdata_r;
    assign i_ready = i_ready_r;
    assign d_ready = d_ready_r;
    assign bus_err = bus_err_r;
    assign i_rdata = i_rdata_r;
    assign d_rdata = d_rdata_r;
    assign stall   = (i_req & ~i_ready_r) | (d_req & ~d_ready_r);

endmodule
